// File: rtl/alu_share_ctl_pkg.sv
// Shared types for the two-requester ALU share controller.
// Holds FSM state encodings and default widths.
package alu_pkg;

    localparam int DW_DEF = 8;
    localparam int OW_DEF = 4;
    localparam int LAT_W  = 3;
    localparam int LCNT_W = 8;

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } st_e;

endpackage

// File: rtl/alu_share_ctl_if.sv
// Request, response and ALU-side signals of the share controller.
// slave = controller view, master = requesters/ALU view.
interface alu_share_ctl_if #(
    parameter int DW = 8,
    parameter int OW = 4
) ();

    logic          REQ0_VLD;
    logic          REQ0_RDY;
    logic          REQ0_LCK;
    logic [OW-1:0] REQ0_OPT;
    logic [DW-1:0] REQ0_RGA;
    logic [DW-1:0] REQ0_RGB;
    logic          REQ1_VLD;
    logic          REQ1_RDY;
    logic          REQ1_LCK;
    logic [OW-1:0] REQ1_OPT;
    logic [DW-1:0] REQ1_RGA;
    logic [DW-1:0] REQ1_RGB;
    logic          RSP0_VLD;
    logic          RSP0_RDY;
    logic          RSP1_VLD;
    logic          RSP1_RDY;
    logic [DW-1:0] RSP_RGZ;
    logic          ALU_RST;
    logic          ALU_ENA;
    logic [OW-1:0] ALU_OPT;
    logic [DW-1:0] ALU_RGA;
    logic [DW-1:0] ALU_RGB;
    logic [DW-1:0] ALU_RGZ;

    modport slave (
        input  REQ0_VLD, REQ0_LCK, REQ0_OPT,
        input  REQ0_RGA, REQ0_RGB,
        input  REQ1_VLD, REQ1_LCK, REQ1_OPT,
        input  REQ1_RGA, REQ1_RGB,
        input  RSP0_RDY, RSP1_RDY, ALU_RGZ,
        output REQ0_RDY, REQ1_RDY,
        output RSP0_VLD, RSP1_VLD, RSP_RGZ,
        output ALU_RST, ALU_ENA, ALU_OPT,
        output ALU_RGA, ALU_RGB
    );

    modport master (
        output REQ0_VLD, REQ0_LCK, REQ0_OPT,
        output REQ0_RGA, REQ0_RGB,
        output REQ1_VLD, REQ1_LCK, REQ1_OPT,
        output REQ1_RGA, REQ1_RGB,
        output RSP0_RDY, RSP1_RDY, ALU_RGZ,
        input  REQ0_RDY, REQ1_RDY,
        input  RSP0_VLD, RSP1_VLD, RSP_RGZ,
        input  ALU_RST, ALU_ENA, ALU_OPT,
        input  ALU_RGA, ALU_RGB
    );

endinterface

// File: rtl/alu_share_ctl_arb.sv
// alu_rr_arb2: 2-way grant with pointer and lock mask.
// ALU_FIXED_PRIO_EN: requester 0 wins unlocked contention.
module alu_rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] vld,
    input  logic       ptr,
    input  logic       hld,
    input  logic       own,
    output logic       gnt,
    output logic       gid
);

`ifdef ALU_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr;
`endif

    // a held lock masks everyone but the owner
    always_comb begin
        gnt = 1'b0;
        gid = 1'b0;
        if (hld) begin
            gid = own;
            gnt = vld[own];
        end else begin
            gnt = |vld;
`ifdef ALU_FIXED_PRIO_EN
            gid = ~vld[0];
`else
            gid = vld[ptr] ? ptr : ~ptr;
`endif
        end
    end

endmodule

// File: rtl/alu_share_ctl.sv
// Shares one registered ALU between two requesters.
// Define ALU_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_share_ctl
    import alu_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int OW       = OW_DEF,
    parameter int ALU_LAT  = 1,
    parameter int LOCK_MAX = 15
) (
    input logic CLK,
    input logic RST,
    alu_share_ctl_if.slave bus
);

    st_e st_q;
    st_e st_d;

    logic              ptr_q;
    logic              gid_q;
    logic              own_q;
    logic [LCNT_W-1:0] lcnt_q;
    logic [LAT_W-1:0]  wcnt_q;
    logic [OW-1:0]     opt_q;
    logic [DW-1:0]     rga_q;
    logic [DW-1:0]     rgb_q;
    logic [DW-1:0]     rgz_q;

    logic        hld;
    logic        gnt;
    logic        gid;
    logic        acc;
    logic        lck;
    logic        rsp_rdy;
    logic        wdone;
    logic        hs;
    logic [8:0]  lnxt;
    logic [1:0]  rdy;
    logic [1:0]  rvld;
    logic        ena;
    logic        arst;

    assign hld     = (lcnt_q != '0);
    assign acc     = (st_q == ST_IDLE) && gnt;
    assign lck     = gid ? bus.REQ1_LCK : bus.REQ0_LCK;
    assign rsp_rdy = gid_q ? bus.RSP1_RDY : bus.RSP0_RDY;
    assign wdone   = (wcnt_q == LAT_W'(ALU_LAT - 1));
    assign hs      = (st_q == ST_RESP) && rsp_rdy;
    assign lnxt    = {1'b0, lcnt_q} + 9'd1;

    alu_rr_arb2 u_arb (
        .vld ({bus.REQ1_VLD, bus.REQ0_VLD}),
        .ptr (ptr_q),
        .hld (hld),
        .own (own_q),
        .gnt (gnt),
        .gid (gid)
    );

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) st_q <= ST_CLR;
        else      st_q <= st_d;
    end

    // sequencing and per-state strobes
    always_comb begin
        st_d = st_q;
        rdy  = 2'b00;
        rvld = 2'b00;
        ena  = 1'b0;
        arst = 1'b0;
        unique case (st_q)
            ST_CLR: begin
                arst = 1'b1;
                st_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (gnt) begin
                    rdy[gid] = 1'b1;
                    st_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ena  = 1'b1;
                st_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wdone) st_d = ST_RESP;
            end
            ST_RESP: begin
                rvld[gid_q] = 1'b1;
                if (rsp_rdy) st_d = ST_IDLE;
            end
            default: st_d = ST_CLR;
        endcase
    end

    // ALU latency counter, restarted on every issue
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wcnt_q <= '0;
        end else if (st_q == ST_ISSUE) begin
            wcnt_q <= '0;
        end else if (st_q == ST_WAIT) begin
            wcnt_q <= wcnt_q + LAT_W'(1);
        end
    end

    // operand latch at accept, result capture at end of wait
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gid_q <= 1'b0;
            opt_q <= '0;
            rga_q <= '0;
            rgb_q <= '0;
            rgz_q <= '0;
        end else begin
            if (acc) begin
                gid_q <= gid;
                opt_q <= gid ? bus.REQ1_OPT : bus.REQ0_OPT;
                rga_q <= gid ? bus.REQ1_RGA : bus.REQ0_RGA;
                rgb_q <= gid ? bus.REQ1_RGB : bus.REQ0_RGB;
            end
            if ((st_q == ST_WAIT) && wdone) begin
                rgz_q <= bus.ALU_RGZ;
            end
        end
    end

    // lock owner/count; count hitting LOCK_MAX releases
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            own_q  <= 1'b0;
            lcnt_q <= '0;
        end else if (acc) begin
            if (lck && (lnxt < 9'(LOCK_MAX))) begin
                own_q  <= gid;
                lcnt_q <= lnxt[LCNT_W-1:0];
            end else begin
                own_q  <= 1'b0;
                lcnt_q <= '0;
            end
        end
    end

    // pointer passes to the other side once unlocked
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= 1'b0;
        end else if (hs && !hld) begin
            ptr_q <= ~gid_q;
        end
    end

    assign bus.REQ0_RDY = rdy[0];
    assign bus.REQ1_RDY = rdy[1];
    assign bus.RSP0_VLD = rvld[0];
    assign bus.RSP1_VLD = rvld[1];
    assign bus.RSP_RGZ  = rgz_q;
    assign bus.ALU_RST  = arst;
    assign bus.ALU_ENA  = ena;
    assign bus.ALU_OPT  = opt_q;
    assign bus.ALU_RGA  = rga_q;
    assign bus.ALU_RGB  = rgb_q;

endmodule
